mac_operand_feeder: RTL and testbench

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

---
 rtl/mac_operand_feeder.sv | 138 +++++++++++++
 tb/tb_mac_operand_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers data/weight operands and streams them in pairs to a MAC.
// Ports: clk, rst (sync, active-high); wr_en/wr_sel/wr_addr/wr_value load the buffers
// while idle; len/start launch a job; data/weight carry {valid,value} to the MAC;
// mac_clr clears the accumulator; busy marks a job in flight; done pulses when the
// MAC result is final; err is sticky after a start with an illegal len.
package mac_operand_feeder_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
  } scalar_t;
endpackage

module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int MAC_LAT = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_value,
  input  logic [AW:0]   len,
  input  logic          start,
  output scalar_t       data,
  output scalar_t       weight,
  output logic          mac_clr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          DW    = $clog2(MAC_LAT + 1) + 1;
  localparam logic [AW:0] LMAX  = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] DLAST =
    DW'(MAC_LAT > 0 ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]   r_dbuf [DEPTH];
  logic [31:0]   r_wbuf [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic [DW-1:0] r_drain;
  logic          r_err;

  logic w_idle;
  logic w_strm;
  logic w_len_ok;
  logic w_last;
  logic w_drain_last;

  assign w_idle       = (r_state == S_IDLE);
  assign w_strm       = (r_state == S_STREAM);
  assign w_len_ok     = (len != '0) && (len <= LMAX);
  assign w_last       = (r_idx == r_last);
  assign w_drain_last = (r_drain == DLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start && w_len_ok) w_next = S_CLEAR;
      end
      S_CLEAR: w_next = S_STREAM;
      S_STREAM: begin
        // With no MAC latency the result is final right after the last pair.
        if (w_last) w_next = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_last) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Index counter wraps only when the job covers the whole buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_last  <= '0;
      r_drain <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && start) begin
        if (w_len_ok) begin
          r_last <= AW'(len - 1'b1);
          r_err  <= 1'b0;
        end else begin
          r_err  <= 1'b1;
        end
      end
      r_idx   <= w_strm ? r_idx + 1'b1 : '0;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
    end
  end

  // Buffers are not reset so their contents survive an aborted job.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && w_idle) begin
      if (wr_sel) r_wbuf[wr_addr] <= wr_value;
      else        r_dbuf[wr_addr] <= wr_value;
    end
  end

  assign data   = '{valid: w_strm,
                    value: w_strm ? r_dbuf[r_idx] : 32'h0};
  assign weight = '{valid: w_strm,
                    value: w_strm ? r_wbuf[r_idx] : 32'h0};

  assign mac_clr = (r_state == S_CLEAR);
  assign busy    = (r_state == S_CLEAR) || w_strm ||
                   (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: random and directed stimulus against a timeline model.
// Each cycle compares control flags, data and weight operands.
module tb_mac_operand_feeder;
  import mac_operand_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int ML    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [31:0] wr_value;
  logic [4:0]  len;
  logic        start;
  scalar_t     data;
  scalar_t     weight;
  logic        mac_clr;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_d [DEPTH];
  logic [31:0] m_w [DEPTH];
  bit          m_job;
  int          m_off;
  int          m_len;
  bit          m_err;

  mac_operand_feeder #(.DEPTH(DEPTH), .MAC_LAT(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_value (wr_value),
    .len      (len),
    .start    (start),
    .data     (data),
    .weight   (weight),
    .mac_clr  (mac_clr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fbits(input int i);
    int e;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    return 32'((127 + e) << 23) |
           (32'(i << (23 - e)) & 32'h007F_FFFF);
  endfunction

  // Job timeline offset: 1 clear, 2..len+1 stream,
  // then ML drain cycles, then one done cycle.
  task automatic step(input logic we, input logic ws,
                      input logic [3:0] wa, input logic [31:0] wv,
                      input logic [4:0] ln, input logic st,
                      input logic rs);
    logic [5:0]  ectl;
    logic [31:0] ed;
    logic [31:0] ew;
    int          tot;
    wr_en = we; wr_sel = ws; wr_addr = wa; wr_value = wv;
    len = ln; start = st; rst = rs;
    @(negedge clk);
    ectl = '0; ed = '0; ew = '0;
    tot = m_len + ML;
    if (m_job) begin
      ectl[5] = (m_off == 1);
      ectl[4] = (m_off <= tot + 1);
      ectl[3] = (m_off == tot + 2);
      if (m_off >= 2 && m_off <= m_len + 1) begin
        ectl[1] = 1'b1;
        ectl[0] = 1'b1;
        ed = m_d[m_off-2];
        ew = m_w[m_off-2];
      end
    end
    ectl[2] = m_err;
    chk("ctl", {58'b0, mac_clr, busy, done, err,
                data.valid, weight.valid}, {58'b0, ectl});
    chk("data", {32'b0, data.value}, {32'b0, ed});
    chk("weight", {32'b0, weight.value}, {32'b0, ew});
    @(posedge clk);
    if (rs) begin
      m_job = 0;
      m_err = 0;
    end else if (!m_job) begin
      if (we) begin
        if (ws) m_w[wa] = wv;
        else    m_d[wa] = wv;
      end
      if (st) begin
        if (ln >= 1 && ln <= DEPTH) begin
          m_job = 1; m_off = 1; m_len = int'(ln); m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_off == m_len + ML + 2) begin
      m_job = 0;
    end else begin
      m_off++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input logic [4:0] ln);
    step(0, 0, 0, 0, ln, 1, 0);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_sel = 0; wr_addr = 0;
    wr_value = 0; len = 0; start = 0;
    m_job = 0; m_err = 0; m_off = 0; m_len = 0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 4'(i), $urandom, 0, 0, 0);
      step(1, 1, 4'(i), $urandom, 0, 0, 0);
    end

    // 5.0 x 5.0 over three pairs
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'(i), 32'h40A0_0000, 0, 0, 0);
      step(1, 1, 4'(i), 32'h40A0_0000, 0, 0, 0);
    end
    go(3);
    idle(9);

    // illegal lengths, then a legal start clears err
    go(0);
    idle(2);
    go(17);
    idle(2);
    go(1);
    idle(6);

    // full-depth stream of 1.0..16.0
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 4'(i), fbits(i + 1), 0, 0, 0);
      step(1, 1, 4'(i), fbits(DEPTH - i), 0, 0, 0);
    end
    go(16);
    idle(22);

    // reset while streaming index 1, then restart
    go(3);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    go(3);
    idle(8);

    // writes and starts during a job are ignored
    go(4);
    for (int i = 0; i < 8; i++)
      step(1, i[0], 4'(i), $urandom, 5'd2, 1, 0);
    idle(4);

    // start on the done cycle is ignored, next cycle accepted
    go(1);
    idle(4);
    go(2);
    go(2);
    idle(8);

    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)),
           4'($urandom), $urandom, 5'($urandom_range(17)),
           $urandom_range(5) == 0, $urandom_range(63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
